// File: rtl/harmonic_scheduler.sv
// harmonic_scheduler: time-multiplexed additive-synth sequencer.
// On each accepted sample tick it walks every partial once, advancing its phase,
// issuing the phase to the shared sine LUT, scaling the returned sample by the
// partial amplitude and summing everything into one saturated output sample.
module harmonic_scheduler #(
    parameter int unsigned NUM_PARTIALS = 16,
    parameter int unsigned LUT_LAT      = 2,
    parameter int unsigned LUT_AW       = 10
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic                            enable,
    input  logic                            sample_tick,
    input  logic                            cfg_we,
    input  logic                            cfg_sel,
    input  logic [$clog2(NUM_PARTIALS)-1:0] cfg_addr,
    input  logic [31:0]                     cfg_wdata,
    input  logic                            overrun_clr,
    output logic [LUT_AW-1:0]               lut_addr,
    output logic                            lut_valid,
    input  logic [15:0]                     lut_data,
    output logic [15:0]                     sample_out,
    output logic                            sample_valid,
    output logic                            busy,
    output logic                            overrun
);

    localparam int unsigned IW = $clog2(NUM_PARTIALS);
    // Counter serves as the partial index in RUN and the drain count in DRAIN.
    localparam int unsigned CW = IW + 3;
    localparam int unsigned AW = 17 + IW;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q;
    logic [31:0]           phase_acc_q [NUM_PARTIALS];
    logic [31:0]           inc_q       [NUM_PARTIALS];
    logic [15:0]           amp_q       [NUM_PARTIALS];
    logic [15:0]           amp_pipe_q  [LUT_LAT];
    logic [LUT_LAT-1:0]    vld_pipe_q;
    logic signed [AW-1:0]  acc_q;
    logic [15:0]           sample_out_q;
    logic                  sample_valid_q;
    logic                  overrun_q;

    logic [IW-1:0]         idx;
    logic                  tick_accept;
    logic                  tick_drop;
    logic                  run_last;
    logic                  drain_last;
    logic signed [32:0]    product;
    logic                  in_range;
    logic [15:0]           sat_sample;

    assign idx         = cnt_q[IW-1:0];
    assign tick_accept = (state_q == StIdle) && sample_tick && enable;
    assign tick_drop   = (state_q != StIdle) && sample_tick;
    assign run_last    = (cnt_q == CW'(NUM_PARTIALS - 1));
    assign drain_last  = (cnt_q == CW'(LUT_LAT));

    // lut_data is signed; the amplitude is unsigned, so it gets a zero sign bit.
    assign product = $signed({{17{lut_data[15]}}, lut_data})
                   * $signed({17'b0, amp_pipe_q[LUT_LAT-1]});

    // Accumulator fits in 16 bits when every bit above bit 15 matches the sign.
    assign in_range   = (&acc_q[AW-1:15]) || ~(|acc_q[AW-1:15]);
    assign sat_sample = in_range ? acc_q[15:0] : (acc_q[AW-1] ? 16'h8000 : 16'h7FFF);

    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign overrun      = overrun_q;

    // FSM state register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state_q <= StIdle;
        else          state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (tick_accept) state_d = StRun;
            StRun:   if (run_last)    state_d = StDrain;
            StDrain: if (drain_last)  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs; the LUT address is read from the old phase of the current partial
    always_comb begin
        busy      = (state_q != StIdle);
        lut_valid = (state_q == StRun);
        lut_addr  = '0;
        if (state_q == StRun) lut_addr = phase_acc_q[idx][31 -: LUT_AW];
    end

    // Per-state cycle counter, restarted on every state change
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cnt_q <= '0;
        end else if (state_d != state_q || state_q == StIdle) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Config registers; a write lands at the edge, so a same-cycle read sees the old value
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_PARTIALS; i++) begin
                inc_q[i] <= '0;
                amp_q[i] <= '0;
            end
        end else if (cfg_we) begin
            if (cfg_sel) amp_q[cfg_addr] <= cfg_wdata[15:0];
            else         inc_q[cfg_addr] <= cfg_wdata;
        end
    end

    // Phase accumulators advance as each partial is issued (mod 2^32)
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_PARTIALS; i++) phase_acc_q[i] <= '0;
        end else if (state_q == StRun) begin
            phase_acc_q[idx] <= phase_acc_q[idx] + inc_q[idx];
        end
    end

    // Amplitude travels alongside the LUT request so it meets the returning sample
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            vld_pipe_q <= '0;
            for (int i = 0; i < LUT_LAT; i++) amp_pipe_q[i] <= '0;
        end else begin
            vld_pipe_q[0] <= lut_valid;
            amp_pipe_q[0] <= amp_q[idx];
            for (int i = 1; i < LUT_LAT; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                amp_pipe_q[i] <= amp_pipe_q[i-1];
            end
        end
    end

    // Frame accumulator: cleared on frame start, adds floor(product / 2^16)
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            acc_q <= '0;
        end else if (tick_accept) begin
            acc_q <= '0;
        end else if (vld_pipe_q[LUT_LAT-1]) begin
            acc_q <= acc_q + AW'(product >>> 16);
        end
    end

    // Saturated result is registered on entry to DONE, with a one-cycle valid pulse
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            sample_valid_q <= (state_q == StDrain) && drain_last;
            if ((state_q == StDrain) && drain_last) sample_out_q <= sat_sample;
        end
    end

    // Sticky overrun; a dropped tick wins over a simultaneous clear
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)         overrun_q <= 1'b0;
        else if (tick_drop)   overrun_q <= 1'b1;
        else if (overrun_clr) overrun_q <= 1'b0;
    end

endmodule

// File: tb/tb_harmonic_scheduler.sv
// Self-checking bench for harmonic_scheduler: directed scenarios plus randomized
// config/LUT contents, checked against a frame-level arithmetic model.
module tb_harmonic_scheduler;

    localparam int NP  = 16;
    localparam int LAT = 2;
    localparam int LAW = 10;
    localparam int IW  = 4;
    localparam int FRAME_LEN = NP + LAT + 2;

    logic            ACLK = 1'b0;
    logic            ARESETN = 1'b0;
    logic            enable = 1'b1;
    logic            sample_tick = 1'b0;
    logic            cfg_we = 1'b0;
    logic            cfg_sel = 1'b0;
    logic [IW-1:0]   cfg_addr = '0;
    logic [31:0]     cfg_wdata = '0;
    logic            overrun_clr = 1'b0;
    logic [LAW-1:0]  lut_addr;
    logic            lut_valid;
    logic [15:0]     lut_data = '0;
    logic [15:0]     sample_out;
    logic            sample_valid;
    logic            busy;
    logic            overrun;

    harmonic_scheduler #(
        .NUM_PARTIALS(NP),
        .LUT_LAT     (LAT),
        .LUT_AW      (LAW)
    ) dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .enable      (enable),
        .sample_tick (sample_tick),
        .cfg_we      (cfg_we),
        .cfg_sel     (cfg_sel),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .overrun_clr (overrun_clr),
        .lut_addr    (lut_addr),
        .lut_valid   (lut_valid),
        .lut_data    (lut_data),
        .sample_out  (sample_out),
        .sample_valid(sample_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 ACLK = ~ACLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: configuration and phases per partial.
    int unsigned m_phase [NP];
    int unsigned m_inc   [NP];
    int unsigned m_amp   [NP];

    // Bench LUT: either a constant or a random table.
    bit          use_table = 1'b0;
    logic [15:0] lut_const = 16'h0000;
    logic [15:0] lut_mem [1 << LAW];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] lut_value(input logic [LAW-1:0] a);
        return use_table ? lut_mem[a] : lut_const;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NP; k++) begin
            m_phase[k] = 0;
            m_inc[k]   = 0;
            m_amp[k]   = 0;
        end
    endtask

    // LUT responder: data for a request shows up LAT cycles later; garbage otherwise.
    logic [LAW-1:0] h_addr [LAT+1];
    bit             h_v    [LAT+1];
    always @(negedge ACLK) begin
        for (int i = LAT; i > 0; i--) begin
            h_addr[i] = h_addr[i-1];
            h_v[i]    = h_v[i-1];
        end
        h_addr[0] = lut_addr;
        h_v[0]    = lut_valid;
        lut_data  = h_v[LAT] ? lut_value(h_addr[LAT]) : 16'($urandom);
    end

    task automatic cfg_write(input bit sel, input int unsigned addr, input logic [31:0] d);
        @(negedge ACLK);
        cfg_we    = 1'b1;
        cfg_sel   = sel;
        cfg_addr  = IW'(addr);
        cfg_wdata = d;
        @(negedge ACLK);
        cfg_we = 1'b0;
        if (sel) m_amp[addr] = {16'h0, d[15:0]};
        else     m_inc[addr] = d;
    endtask

    // One frame: tick, then check every cycle through the first idle cycle.
    // xtick_at / amp_k schedule an extra tick or an amplitude write at cycle T+i.
    task automatic run_frame(input int xtick_at, input bit xclr, input int amp_k,
                             input logic [15:0] amp_v);
        logic [LAW-1:0] ea [NP];
        longint         sum;
        longint         d;
        logic [15:0]    es;
        sum = 0;
        for (int k = 0; k < NP; k++) begin
            ea[k] = LAW'(m_phase[k] >> (32 - LAW));
            d     = longint'($signed(lut_value(ea[k])));
            sum  += (d * longint'(m_amp[k])) >>> 16;
            m_phase[k] += m_inc[k];
        end
        if (sum > 32767)       es = 16'h7FFF;
        else if (sum < -32768) es = 16'h8000;
        else                   es = 16'(sum);

        @(negedge ACLK);
        sample_tick = 1'b1;
        for (int i = 1; i <= FRAME_LEN + 1; i++) begin
            @(negedge ACLK);
            sample_tick = 1'b0;
            overrun_clr = 1'b0;
            cfg_we      = 1'b0;
            check_eq("busy", 32'(busy), 32'(i <= FRAME_LEN));
            check_eq("lut_valid", 32'(lut_valid), 32'(i <= NP));
            if (i <= NP) check_eq($sformatf("lut_addr[k=%0d]", i - 1), 32'(lut_addr), 32'(ea[i-1]));
            check_eq("sample_valid", 32'(sample_valid), 32'(i == FRAME_LEN));
            if (i == FRAME_LEN) check_eq("sample_out", 32'(sample_out), 32'(es));
            if (i == xtick_at) begin
                sample_tick = 1'b1;
                overrun_clr = xclr;
            end
            if (amp_k >= 0 && i == amp_k + 1) begin
                cfg_we    = 1'b1;
                cfg_sel   = 1'b1;
                cfg_addr  = IW'(amp_k);
                cfg_wdata = {16'h0, amp_v};
            end
        end
        if (amp_k >= 0) m_amp[amp_k] = {16'h0, amp_v};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << LAW); i++) lut_mem[i] = 16'($urandom);
        for (int i = 0; i <= LAT; i++) begin
            h_addr[i] = '0;
            h_v[i]    = 1'b0;
        end
        model_reset();

        // Reset state
        repeat (3) @(negedge ACLK);
        check_eq("rst busy", 32'(busy), 0);
        check_eq("rst lut_valid", 32'(lut_valid), 0);
        ARESETN = 1'b1;
        @(negedge ACLK);
        check_eq("rst sample_out", 32'(sample_out), 0);
        check_eq("rst sample_valid", 32'(sample_valid), 0);
        check_eq("rst busy2", 32'(busy), 0);
        check_eq("rst overrun", 32'(overrun), 0);
        check_eq("rst lut_valid2", 32'(lut_valid), 0);

        // Single partial: first frame all addresses 0, result 16383; then addr 4
        lut_const = 16'h4000;
        cfg_write(1'b0, 0, 32'h0100_0000);
        cfg_write(1'b1, 0, 32'h0000_FFFF);
        run_frame(-1, 1'b0, -1, 16'h0);
        run_frame(-1, 1'b0, -1, 16'h0);

        // Phase wrap on partial 3: 0x000, 0x200, 0x000
        cfg_write(1'b0, 3, 32'h8000_0000);
        repeat (3) run_frame(-1, 1'b0, -1, 16'h0);

        // Saturation both ways
        for (int k = 0; k < NP; k++) cfg_write(1'b1, k, 32'h0000_FFFF);
        lut_const = 16'h7FFF;
        run_frame(-1, 1'b0, -1, 16'h0);
        lut_const = 16'h8000;
        run_frame(-1, 1'b0, -1, 16'h0);

        // Overrun: tick at T+5 dropped; then clear colliding with a DONE-cycle tick
        lut_const = 16'h4000;
        check_eq("overrun pre", 32'(overrun), 0);
        run_frame(5, 1'b0, -1, 16'h0);
        check_eq("overrun set", 32'(overrun), 1);
        run_frame(FRAME_LEN, 1'b1, -1, 16'h0);
        check_eq("overrun set wins", 32'(overrun), 1);
        @(negedge ACLK);
        overrun_clr = 1'b1;
        @(negedge ACLK);
        overrun_clr = 1'b0;
        check_eq("overrun cleared", 32'(overrun), 0);

        // Config race on amp[2]: old value this frame, new value next frame
        for (int k = 0; k < NP; k++) cfg_write(1'b1, k, (k == 2) ? 32'h8000 : 32'h0);
        run_frame(-1, 1'b0, 2, 16'h1000);
        run_frame(-1, 1'b0, -1, 16'h0);

        // Tick ignored while enable is low
        @(negedge ACLK);
        enable      = 1'b0;
        sample_tick = 1'b1;
        @(negedge ACLK);
        sample_tick = 1'b0;
        enable      = 1'b1;
        check_eq("disabled busy", 32'(busy), 0);
        check_eq("disabled lut_valid", 32'(lut_valid), 0);
        check_eq("disabled overrun", 32'(overrun), 0);

        // Randomized configs against a random LUT table
        use_table = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int w = 0; w < 6; w++)
                cfg_write(1'($urandom_range(0, 1)), $urandom_range(0, NP - 1), $urandom);
            run_frame(-1, 1'b0, -1, 16'h0);
        end

        // Reset mid-frame at k = 7
        @(negedge ACLK);
        sample_tick = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge ACLK);
            sample_tick = 1'b0;
        end
        check_eq("midrst lut_valid before", 32'(lut_valid), 1);
        #1 ARESETN = 1'b0;
        #1;
        check_eq("midrst busy", 32'(busy), 0);
        check_eq("midrst lut_valid", 32'(lut_valid), 0);
        check_eq("midrst lut_addr", 32'(lut_addr), 0);
        for (int i = 0; i < FRAME_LEN; i++) begin
            @(negedge ACLK);
            check_eq("midrst sample_valid", 32'(sample_valid), 0);
        end
        ARESETN = 1'b1;
        model_reset();
        @(negedge ACLK);
        check_eq("midrst sample_out", 32'(sample_out), 0);
        run_frame(-1, 1'b0, -1, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/harmonic_scheduler.md
# harmonic_scheduler

- Time-multiplexed sequencer for the additive-synth DDS datapath.
- On each audio sample tick it walks all partials in order: advances each partial's phase accumulator, issues its phase to the shared sine LUT, scales the returned sample by the partial's amplitude, and sums the results into one saturated output sample.
- Sits between the AXI4-Lite register slave (which supplies per-partial config writes) and the audio output path.

## Interface
Parameters:
- NUM_PARTIALS, 16, partials per frame (power of two, 2..64)
- LUT_LAT, 2, fixed read latency of the sine LUT in cycles (1..4)
- LUT_AW, 10, LUT address width (top bits of the 32-bit phase)

Ports (clock and reset: one clock, `ACLK`; `ARESETN` is an asynchronous, active-low reset):
- ACLK  in  1  system clock
- ARESETN  in  1  asynchronous active-low reset
- enable  in  1  when low, sample_tick is ignored; a frame in progress still completes
- sample_tick  in  1  one-cycle pulse that starts a frame
- cfg_we  in  1  config write strobe
- cfg_sel  in  1  0 = phase increment, 1 = amplitude
- cfg_addr  in  clog2(NUM_PARTIALS)  partial index
- cfg_wdata  in  32  increment: all 32 bits; amplitude: bits [15:0], unsigned
- overrun_clr  in  1  clears overrun
- lut_addr  out  LUT_AW  phase_acc[k][31:32-LUT_AW]
- lut_valid  out  1  lut_addr valid this cycle
- lut_data  in  16  signed sine sample, valid exactly LUT_LAT cycles after lut_valid
- sample_out  out  16  signed, saturated frame sum; held until the next frame
- sample_valid  out  1  one-cycle pulse when sample_out updates
- busy  out  1  frame in progress
- overrun  out  1  sticky: a tick arrived while busy

## Operation
States:
- IDLE: a tick is accepted when the tick is high, enable is high and busy is low.
- RUN: NUM_PARTIALS cycles, with index k = 0..N-1.
- DRAIN: LUT_LAT+1 cycles.
- DONE: 1 cycle, then back to IDLE.

RUN, per partial k:
- Drive lut_addr from the old phase_acc[k] with lut_valid = 1.
- Write phase_acc[k] <= phase_acc[k] + inc[k], mod 2^32 (wrap, no flag).
- amp[k] is sampled at issue time and pipelined alongside the LUT request.

Datapath arithmetic:
- Product = lut_data (signed 16) × {1'b0, amp} (signed 17), a 33-bit signed value.
- Contribution = product >>> 16 (arithmetic shift, floor), 17 bits.
- The accumulator is 17 + clog2(N) bits, cleared at frame start.

DONE:
- Clamp the accumulator to [-32768, 32767] and register it into sample_out.
- Pulse sample_valid.

Config writes:
- Any cycle, single-cycle effect.
- A write to the index being read in the same cycle is not seen by that read (old value used); it takes effect from the next frame.

Overrun:
- A tick while busy is high (including the DONE cycle) is dropped and sets overrun.
- overrun_clr clears it; if a clear and a new overrun occur in the same cycle, set wins.

Reset (ARESETN low), immediate and asynchronous:
- FSM goes to IDLE.
- phase_acc[], inc[], amp[], accumulator, sample_out, overrun all go to 0.
- busy, lut_valid, sample_valid go to 0; lut_addr goes to 0.
- Reset mid-frame aborts the frame with no sample_valid.

## Timing
- Tick sampled high at edge T.
- Partial k is issued in cycle T+1+k.
- Its lut_data is valid in cycle T+1+k+LUT_LAT and is accumulated at the end of that cycle.
- sample_valid is high in cycle T+N+LUT_LAT+2, which is 20 cycles after the tick for the defaults.
- busy is high from cycle T+1 through the sample_valid cycle inclusive; the next tick is accepted the cycle after.
- Minimum tick spacing without overrun: N+LUT_LAT+3 cycles.
- lut_valid is high for exactly N consecutive cycles per frame.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** hold ARESETN low, then release -> sample_out = 0, sample_valid = 0, busy = 0, overrun = 0, lut_valid = 0; the first frame issues lut_addr = 0 for every k.
- **Single partial:** inc[0] = 0x0100_0000, amp[0] = 0xFFFF, other amps 0; bench LUT returns a constant 0x4000.
  - Tick -> sample_valid exactly 20 cycles later with sample_out = 16383.
  - Second frame issues lut_addr = 0x004 for k = 0.
- **Saturation:**
  - All amps 0xFFFF, LUT = 0x7FFF -> sample_out = 0x7FFF.
  - All amps 0xFFFF, LUT = 0x8000 -> sample_out = 0x8000 (each contribution is -32768).
- **Phase wrap:** inc[3] = 0x8000_0000 -> lut_addr for k = 3 over three frames is 0x000, 0x200, 0x000.
- **Overrun and config race:**
  - Tick in cycle T+5 -> ignored, overrun = 1, frame result unchanged.
  - overrun_clr in the same cycle as a new dropped tick -> overrun stays 1.
  - Writing amp[2] in its issue cycle -> the old value is used in this frame and the new value in the next.
- **Reset mid-frame:** assert ARESETN low during RUN (k = 7) -> busy and lut_valid drop immediately, no sample_valid; after release, a tick produces sample_out computed from zero phases and zero amps = 0.
